// File: rtl/sen_lut_reader.sv
// Sweep sequencer for the combinational sine lookup memory: walks base, base+step, ...
// modulo AMOUNT and streams the registered samples out on a valid/ready interface.
module sen_lut_reader #(
  parameter int unsigned WIDTH  = 24,
  parameter int unsigned AMOUNT = 302,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W-1:0] i_step,
  input  logic [CNT_W-1:0]  i_count,
  output logic              o_busy,
  output logic              o_done,
  output logic [WIDTH-1:0]  o_mem_a,
  input  logic [WIDTH-1:0]  i_mem_rd,
  output logic [WIDTH-1:0]  o_out_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_out_last
);

  localparam logic [ADDR_W:0] LpAmount = (ADDR_W + 1)'(AMOUNT);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e             r_state, w_state_d;
  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W-1:0]  r_step;
  logic [CNT_W-1:0]   r_remaining;
  logic [WIDTH-1:0]   r_out_data;
  logic               r_out_valid;
  logic               r_out_last;

  logic               w_start;
  logic               w_load;
  logic               w_accept;
  logic [ADDR_W:0]    w_sum;
  logic [ADDR_W:0]    w_wrap;
  logic [ADDR_W:0]    w_step_ext;
  logic [ADDR_W:0]    w_step_adj;
  logic               w_base_oob;

  assign w_start  = (r_state == StIdle) && i_start;
  assign w_accept = r_out_valid && i_out_ready;
  assign w_load   = (r_state == StRun) && (r_remaining != '0) && (!r_out_valid || i_out_ready);

  // Both operands are already < AMOUNT, so a single conditional subtract wraps the sum.
  assign w_sum      = {1'b0, r_addr} + {1'b0, r_step};
  assign w_wrap     = (w_sum >= LpAmount) ? (w_sum - LpAmount) : w_sum;
  assign w_step_ext = {1'b0, i_step};
  assign w_step_adj = (w_step_ext >= LpAmount) ? (w_step_ext - LpAmount) : w_step_ext;
  assign w_base_oob = ({1'b0, i_base} >= LpAmount);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_d = (i_count == '0) ? StFin : StRun;
        end
      end
      StRun: begin
        if (w_accept && r_out_last) begin
          w_state_d = StFin;
        end
      end
      StFin:   w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    o_busy = 1'b0;
    o_done = 1'b0;
    unique case (r_state)
      StIdle:  o_busy = 1'b0;
      StRun:   o_busy = 1'b1;
      StFin: begin
        o_busy = 1'b1;
        o_done = 1'b1;
      end
      default: o_busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_step      <= '0;
      r_remaining <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_start) begin
      r_addr      <= w_base_oob ? '0 : i_base;
      r_step      <= w_step_adj[ADDR_W-1:0];
      r_remaining <= i_count;
    end else if (w_load) begin
      r_out_data  <= i_mem_rd;
      r_out_valid <= 1'b1;
      r_out_last  <= (r_remaining == CNT_W'(1));
      r_remaining <= r_remaining - CNT_W'(1);
      r_addr      <= w_wrap[ADDR_W-1:0];
    end else if (w_accept) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  assign o_mem_a     = {{(WIDTH - ADDR_W){1'b0}}, r_addr};
  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_out_last  = r_out_last;

endmodule

// File: tb/tb_sen_lut_reader.sv
// Directed bench for sen_lut_reader against a table model holding mem[i] = i*3.
module tb_sen_lut_reader;

  localparam int unsigned WIDTH  = 24;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] step;
  logic [CNT_W-1:0]  count;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  mem_a;
  logic [WIDTH-1:0]  mem_rd;
  logic [WIDTH-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign mem_rd = WIDTH'(mem_a * 3);

  sen_lut_reader #(
    .WIDTH  (WIDTH),
    .AMOUNT (302),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (start),
    .i_base      (base),
    .i_step      (step),
    .i_count     (count),
    .o_busy      (busy),
    .o_done      (done),
    .o_mem_a     (mem_a),
    .i_mem_rd    (mem_rd),
    .o_out_data  (out_data),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_last  (out_last)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_sample(input string tag, input int data, input bit last);
    chk({tag, " valid"}, 32'(out_valid), 32'd1);
    chk({tag, " data"},  32'(out_data),  32'(data));
    chk({tag, " last"},  32'(out_last),  32'(last));
  endtask

  task automatic go(input int b, input int s, input int c);
    base  = ADDR_W'(b);
    step  = ADDR_W'(s);
    count = CNT_W'(c);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base = '0; step = '0; count = '0; out_ready = 1'b1;
    tick();
    tick();
    chk("rst valid", 32'(out_valid), 0);
    chk("rst busy",  32'(busy),      0);
    chk("rst done",  32'(done),      0);
    chk("rst data",  32'(out_data),  0);
    chk("rst mem_a", 32'(mem_a),     0);
    rst_n = 1'b1;
    tick();

    // 1: basic sweep, full throughput
    go(0, 1, 4);
    chk("t1 busy",      32'(busy),      1);
    chk("t1 no valid",  32'(out_valid), 0);
    tick(); chk_sample("t1 s0", 0, 0);
    tick(); chk_sample("t1 s1", 3, 0);
    tick(); chk_sample("t1 s2", 6, 0);
    tick(); chk_sample("t1 s3", 9, 1);
    tick();
    chk("t1 done",      32'(done),      1);
    chk("t1 drained",   32'(out_valid), 0);
    tick();
    chk("t1 done off",  32'(done),      0);
    chk("t1 idle busy", 32'(busy),      0);

    // 2: address wrap past the table end
    go(300, 1, 4);
    tick(); chk_sample("t2 s0", 900, 0);
    tick(); chk_sample("t2 s1", 903, 0);
    tick(); chk_sample("t2 s2", 0, 0);
    tick(); chk_sample("t2 s3", 3, 1);
    tick(); chk("t2 done", 32'(done), 1);
    tick();

    // 3: consumer stall holds the sample and freezes the walk
    out_ready = 1'b0;
    go(10, 2, 3);
    tick(); chk_sample("t3 s0", 30, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_sample("t3 hold", 30, 0);
      chk("t3 mem_a frozen", 32'(mem_a), 12);
    end
    out_ready = 1'b1;
    tick(); chk_sample("t3 s1", 36, 0);
    tick(); chk_sample("t3 s2", 42, 1);
    tick(); chk("t3 done", 32'(done), 1);
    chk("t3 drained", 32'(out_valid), 0);
    tick();

    // 4: empty sweep
    go(7, 1, 0);
    chk("t4 busy",     32'(busy),      1);
    chk("t4 done",     32'(done),      1);
    chk("t4 no valid", 32'(out_valid), 0);
    tick();
    chk("t4 busy off", 32'(busy),      0);
    chk("t4 done off", 32'(done),      0);

    // 5: asynchronous reset mid-sweep, then a fresh single-sample sweep
    go(0, 1, 8);
    tick(); chk_sample("t5 s0", 0, 0);
    tick(); chk_sample("t5 s1", 3, 0);
    rst_n = 1'b0;
    #1;
    chk("t5 rst valid", 32'(out_valid), 0);
    chk("t5 rst data",  32'(out_data),  0);
    chk("t5 rst busy",  32'(busy),      0);
    chk("t5 rst mem_a", 32'(mem_a),     0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t5 no done", 32'(done), 0);
    go(5, 0, 1);
    tick(); chk_sample("t5 single", 15, 1);
    tick(); chk("t5 done", 32'(done), 1);
    tick();

    // 6: start held through a sweep with a different base is ignored
    go(20, 3, 4);
    base  = ADDR_W'(100);
    start = 1'b1;
    tick(); chk_sample("t6 s0", 60, 0);
    tick(); chk_sample("t6 s1", 69, 0);
    tick(); chk_sample("t6 s2", 78, 0);
    tick(); chk_sample("t6 s3", 87, 1);
    tick(); chk("t6 done", 32'(done), 1);
    start = 1'b0;
    tick();
    chk("t6 no restart", 32'(busy),      0);
    chk("t6 no valid",   32'(out_valid), 0);

    // 7: out-of-range base clamps to 0, oversize step reduced once
    go(400, 303, 2);
    tick(); chk_sample("t7 s0", 0, 0);
    tick(); chk_sample("t7 s1", 3, 1);
    tick(); chk("t7 done", 32'(done), 1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
